load_store_unit: RTL and testbench



---
 rtl/load_store_unit.sv | 197 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Data-memory load/store unit: single-outstanding req/ack bus master with
// RV32I lane steering, load extension, alignment checks and a bus timeout.
//
// state  | meaning
// IDLE   | waiting for mem_read/mem_write from decode
// ACCESS | bus_req asserted, waiting for bus_ack or timeout
// RESP   | one-cycle done pulse with result and fault flags
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        done,
    output logic        stall,
    output logic        misaligned,
    output logic        access_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t         state;
    state_t         state_nxt;
    logic           req_any;
    logic           enc_ok;
    logic           algn_ok;
    logic           req_ok;
    logic [2:0]     f3_q;
    logic [1:0]     alo_q;
    logic           wr_q;
    logic [CW-1:0]  to_cnt;
    logic           to_hit;
    logic [31:0]    wdata_nxt;
    logic [3:0]     wstrb_nxt;
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;
    logic [31:0]    ld_ext;

    // a simultaneous read and write is treated as a write
    assign req_any = mem_read | mem_write;

    // last ACCESS cycle allowed without an ack; TIMEOUT=0 never fires
    assign to_hit = (TIMEOUT != 0) && !bus_ack && (to_cnt == TO_LAST);

    // legality of funct3 for the requested op and natural alignment
    always_comb begin
        enc_ok  = 1'b0;
        algn_ok = 1'b0;
        case (funct3)
            3'b000: begin enc_ok = 1'b1;       algn_ok = 1'b1;              end
            3'b001: begin enc_ok = 1'b1;       algn_ok = ~addr[0];          end
            3'b010: begin enc_ok = 1'b1;       algn_ok = (addr[1:0] == 2'b00); end
            3'b100: begin enc_ok = ~mem_write; algn_ok = 1'b1;              end
            3'b101: begin enc_ok = ~mem_write; algn_ok = ~addr[0];          end
            default: ;
        endcase
        req_ok = enc_ok & algn_ok;
    end

    // store data replication and byte strobes
    always_comb begin
        wdata_nxt = store_data;
        wstrb_nxt = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                wdata_nxt = {4{store_data[7:0]}};
                wstrb_nxt = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                wdata_nxt = {2{store_data[15:0]}};
                wstrb_nxt = 4'b0011 << {addr[1], 1'b0};
            end
            default: ;
        endcase
    end

    // lane select from the read word and sign/zero extension
    always_comb begin
        ld_byte = bus_rdata[7:0];
        case (alo_q)
            2'b01:   ld_byte = bus_rdata[15:8];
            2'b10:   ld_byte = bus_rdata[23:16];
            2'b11:   ld_byte = bus_rdata[31:24];
            default: ;
        endcase
        ld_half = alo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = bus_rdata;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_any) state_nxt = req_ok ? ACCESS : RESP;
            ACCESS:  if (bus_ack || to_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // pipeline hold: released in RESP so decode advances on that edge
    always_comb begin
        stall = 1'b0;
        if ((state == IDLE && req_any) || state == ACCESS) stall = 1'b1;
    end

    // registered bus master outputs, captured request and result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_data    <= '0;
            done         <= 1'b0;
            misaligned   <= 1'b0;
            access_fault <= 1'b0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_wstrb    <= '0;
            f3_q         <= '0;
            alo_q        <= '0;
            wr_q         <= 1'b0;
            to_cnt       <= '0;
        end else begin
            done         <= 1'b0;
            misaligned   <= 1'b0;
            access_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        f3_q  <= funct3;
                        alo_q <= addr[1:0];
                        wr_q  <= mem_write;
                        if (req_ok) begin
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_wdata <= mem_write ? wdata_nxt : 32'h0;
                            bus_wstrb <= mem_write ? wstrb_nxt : 4'h0;
                            to_cnt    <= '0;
                        end else begin
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                            load_data  <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        done      <= 1'b1;
                        load_data <= wr_q ? 32'h0 : ld_ext;
                    end else if (to_hit) begin
                        bus_req      <= 1'b0;
                        done         <= 1'b1;
                        access_fault <= 1'b1;
                        load_data    <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array reference model predicts
// each access, a bus slave model answers requests, a monitor checks results.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [31:0] load_data;
    logic        done;
    logic        stall;
    logic        misaligned;
    logic        access_fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .load_data(load_data), .done(done), .stall(stall),
        .misaligned(misaligned), .access_fault(access_fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ld;
        logic        mis;
        logic        af;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } busx_t;

    resp_t exp_q[$];
    busx_t bus_q[$];
    int    wait_q[$];

    logic [7:0] ref_mem [64];
    logic [7:0] bus_mem [64];

    int n_checks = 0;
    int n_pass = 0;
    bit skip_chk = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
    endtask

    // result monitor
    resp_t m_r;
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 32'(done), 32'h0);
                end else begin
                    m_r = exp_q.pop_front();
                    chk("load_data", load_data, m_r.ld);
                    chk("misaligned", 32'(misaligned), 32'(m_r.mis));
                    chk("access_fault", 32'(access_fault), 32'(m_r.af));
                end
            end else begin
                chk("flags_idle", 32'({misaligned, access_fault}), 32'h0);
            end
        end
    end

    // bus slave: checks each request, acks after the queued wait count
    int          s_w;
    busx_t       s_bx;
    logic [3:0]  s_wi;
    logic        s_we;
    logic [3:0]  s_strb;
    logic [31:0] s_wd;
    initial begin
        forever begin
            @(negedge clk);
            if (bus_req === 1'b1) begin
                if (bus_q.size() == 0 || wait_q.size() == 0) begin
                    chk("bus_req_unexpected", 32'(bus_req), 32'h0);
                    s_w = 0;
                    s_bx.we = bus_we; s_bx.addr = bus_addr;
                    s_bx.wdata = bus_wdata; s_bx.wstrb = bus_wstrb;
                end else begin
                    s_w  = wait_q.pop_front();
                    s_bx = bus_q.pop_front();
                    chk("bus_we", 32'(bus_we), 32'(s_bx.we));
                    chk("bus_addr", bus_addr, s_bx.addr);
                    chk("bus_wstrb", 32'(bus_wstrb), 32'(s_bx.wstrb));
                    if (s_bx.we) chk("bus_wdata", bus_wdata, s_bx.wdata);
                end
                s_wi = bus_addr[5:2]; s_we = bus_we; s_strb = bus_wstrb; s_wd = bus_wdata;
                for (int i = 1; i <= s_w; i++) begin
                    @(negedge clk);
                    if (i < TO && !skip_chk) begin
                        chk("bus_req_hold", 32'(bus_req), 32'h1);
                        chk("bus_addr_hold", bus_addr, s_bx.addr);
                    end else if (i == TO) begin
                        chk("bus_req_timeout_drop", 32'(bus_req), 32'h0);
                    end
                end
                bus_rdata = {bus_mem[{s_wi, 2'd3}], bus_mem[{s_wi, 2'd2}],
                             bus_mem[{s_wi, 2'd1}], bus_mem[{s_wi, 2'd0}]};
                bus_ack = 1'b1;
                if (s_w < TO && s_we) begin
                    for (int j = 0; j < 4; j++)
                        if (s_strb[j]) bus_mem[{s_wi, 2'(j)}] = s_wd[8*j +: 8];
                end
                @(negedge clk);
                bus_ack = 1'b0;
                bus_rdata = $urandom;
            end
        end
    end

    task automatic preload(input logic [3:0] wi, input logic [31:0] v);
        for (int j = 0; j < 4; j++) begin
            ref_mem[{wi, 2'(j)}] = v[8*j +: 8];
            bus_mem[{wi, 2'(j)}] = v[8*j +: 8];
        end
    endtask

    task automatic idle(input int n);
        mem_read = 1'b0;
        mem_write = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // reference model + driver for one access; called on a negedge
    task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd,
                         input int w, input bit b2b);
        int          n, lat, cyc, base;
        bit          legal, found;
        logic [31:0] v;
        resp_t       r;
        busx_t       bx;
        n    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        base = int'(a[5:0]);
        if (wr) legal = (f3 <= 3'd2);
        else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal || (base % n) != 0) begin
            r = '{ld: 32'h0, mis: 1'b1, af: 1'b0};
            lat = 1;
        end else begin
            bx.we    = wr;
            bx.addr  = a & ~32'h3;
            bx.wstrb = wr ? 4'(((1 << n) - 1) << (base % 4)) : 4'h0;
            bx.wdata = (n == 1) ? 32'(sd[7:0]) * 32'h01010101 :
                       (n == 2) ? 32'(sd[15:0]) * 32'h00010001 : sd;
            bus_q.push_back(bx);
            wait_q.push_back(w);
            if (w >= TO) begin
                r = '{ld: 32'h0, mis: 1'b0, af: 1'b1};
                lat = TO + 1;
            end else begin
                lat = w + 2;
                if (wr) begin
                    for (int i = 0; i < n; i++) ref_mem[6'(base + i)] = sd[8*i +: 8];
                    r = '{ld: 32'h0, mis: 1'b0, af: 1'b0};
                end else begin
                    v = 32'h0;
                    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[6'(base + i)]) << (8 * i));
                    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
                    r = '{ld: v, mis: 1'b0, af: 1'b0};
                end
            end
        end
        exp_q.push_back(r);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
        if (b2b) @(negedge clk);
        #1;
        chk("stall_request", 32'(stall), 32'h1);
        found = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 40 && !found; c++) begin
            @(negedge clk);
            cyc = c;
            if (done === 1'b1) found = 1'b1;
            else chk("stall_wait", 32'(stall), 32'h1);
        end
        chk("done_seen", 32'(found), 32'h1);
        chk("latency", 32'(cyc), 32'(lat));
        chk("stall_resp", 32'(stall), 32'h0);
    endtask

    int          lf [5] = '{0, 1, 2, 4, 5};
    bit          b2b;
    bit          rd, wr;
    logic [2:0]  f3;
    logic [31:0] a, sd;
    int          w, gap, sel;

    initial begin
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = 8'(i * 37 + 5);
            bus_mem[i] = 8'(i * 37 + 5);
        end
        #1;
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_misaligned", 32'(misaligned), 32'h0);
        chk("rst_access_fault", 32'(access_fault), 32'h0);
        chk("rst_bus_req", 32'(bus_req), 32'h0);
        chk("rst_bus_we", 32'(bus_we), 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_wstrb", 32'(bus_wstrb), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        preload(4'd0, 32'h80FF1234);
        do_op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 1'b0);
        idle(1);
        preload(4'd0, 32'h8001FFFF);
        do_op(1'b1, 1'b0, 3'b101, 32'h002, 32'h0, 3, 1'b0);
        idle(1);
        do_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 1, 1'b0);
        idle(1);
        do_op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 1'b0);
        do_op(1'b1, 1'b0, 3'b011, 32'h040, 32'h0, 0, 1'b1);
        idle(1);
        do_op(1'b0, 1'b1, 3'b010, 32'h020, 32'hCAFEF00D, TO, 1'b0);
        idle(3);

        // reset while a load is in ACCESS
        bus_q.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0, wstrb: 4'h0});
        wait_q.push_back(TO);
        skip_chk = 1'b1;
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h10;
        @(negedge clk);
        chk("rst_mid_req_up", 32'(bus_req), 32'h1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_req_drop", 32'(bus_req), 32'h0);
        mem_read = 1'b0;
        #1;
        chk("rst_mid_idle", 32'(stall), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        skip_chk = 1'b0;
        chk("post_rst_done", 32'(done), 32'h0);
        chk("post_rst_req", 32'(bus_req), 32'h0);
        do_op(1'b0, 1'b1, 3'b000, 32'h003, 32'h0000009A, 0, 1'b0);
        do_op(1'b1, 1'b0, 3'b000, 32'h003, 32'h0, 0, 1'b1);
        idle(2);

        b2b = 1'b0;
        for (int k = 0; k < 250; k++) begin
            sel = $urandom_range(0, 9);
            rd = (sel <= 4) || (sel == 9);
            wr = (sel >= 5);
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            else if (wr) f3 = 3'($urandom_range(0, 2));
            else f3 = 3'(lf[$urandom_range(0, 4)]);
            a = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                else a[1:0] = 2'b00;
            end
            sd = $urandom;
            w = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, 3);
            do_op(rd, wr, f3, a, sd, w, b2b);
            gap = $urandom_range(0, 3);
            if (gap > 0) idle(gap);
            b2b = (gap == 0);
        end

        idle(10);
        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
        chk("bus_q_drained", 32'(bus_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
